// File: rtl/i2c_sensor_poller.sv
// i2c_sensor_poller: drives an I2C master with a periodic pointer write + two-byte read,
// publishes each good sample, counts failed transactions and flags repeated failures.
module i2c_sensor_poller #(
    parameter logic [6:0] SLAVE_ADDR   = 7'h48,
    parameter logic [7:0] PTR_REG      = 8'h00,
    parameter int         POLL_CYCLES  = 20000,
    parameter int         BUSY_TIMEOUT = 16,
    parameter int         MAX_RETRY    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        trigger,
    input  logic        i2c_ready,
    input  logic        i2c_got_ack,
    input  logic [15:0] i2c_read_data,
    output logic        i2c_start,
    output logic [6:0]  i2c_addr,
    output logic [15:0] i2c_data,
    output logic        i2c_rw,
    output logic        i2c_two_bytes,
    output logic [15:0] sample,
    output logic        sample_valid,
    output logic [7:0]  nack_count,
    output logic        busy,
    output logic        fault
);
    localparam int          BW     = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [15:0] RELOAD = 16'(POLL_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE, SETUP_PTR, ISSUE_PTR, WAIT_BUSY_PTR, WAIT_DONE_PTR,
        SETUP_RD, ISSUE_RD, WAIT_BUSY_RD, WAIT_DONE_RD, UPDATE, FAIL
    } state_t;

    state_t         r_state, w_next;
    logic [15:0]    r_timer;
    logic [BW-1:0]  r_bcnt;
    logic [3:0]     r_retry;
    logic [15:0]    r_data;
    logic           r_rd;
    logic [15:0]    r_sample;
    logic           r_valid;
    logic [7:0]     r_nack;
    logic           r_fault;
    logic           w_go, w_bto, w_wait_busy;

    assign w_go        = (r_state == IDLE) && enable && (trigger || r_timer == 16'd0);
    assign w_wait_busy = (r_state == WAIT_BUSY_PTR) || (r_state == WAIT_BUSY_RD);
    assign w_bto       = r_bcnt == BW'(BUSY_TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:          w_next = w_go ? SETUP_PTR : IDLE;
            SETUP_PTR:     w_next = ISSUE_PTR;
            ISSUE_PTR:     w_next = i2c_ready ? WAIT_BUSY_PTR : ISSUE_PTR;
            WAIT_BUSY_PTR: w_next = !i2c_ready ? WAIT_DONE_PTR : w_bto ? FAIL : WAIT_BUSY_PTR;
            WAIT_DONE_PTR: w_next = !i2c_ready ? WAIT_DONE_PTR : i2c_got_ack ? SETUP_RD : FAIL;
            SETUP_RD:      w_next = ISSUE_RD;
            ISSUE_RD:      w_next = i2c_ready ? WAIT_BUSY_RD : ISSUE_RD;
            WAIT_BUSY_RD:  w_next = !i2c_ready ? WAIT_DONE_RD : w_bto ? FAIL : WAIT_BUSY_RD;
            WAIT_DONE_RD:  w_next = !i2c_ready ? WAIT_DONE_RD : i2c_got_ack ? UPDATE : FAIL;
            default:       w_next = IDLE;
        endcase
    end

    always_comb begin
        i2c_start = ((r_state == ISSUE_PTR) || (r_state == ISSUE_RD)) && i2c_ready;
        busy      = r_state != IDLE;
    end

    // Timer only runs in IDLE; it is reloaded on poll start and held for the whole poll.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_timer  <= RELOAD;
            r_bcnt   <= '0;
            r_retry  <= '0;
            r_data   <= '0;
            r_rd     <= 1'b0;
            r_sample <= '0;
            r_valid  <= 1'b0;
            r_nack   <= '0;
            r_fault  <= 1'b0;
        end else begin
            r_timer <= (r_state != IDLE || !enable || w_go) ? RELOAD : r_timer - 16'd1;
            r_bcnt  <= w_wait_busy ? r_bcnt + BW'(1) : '0;
            r_data  <= (r_state == SETUP_PTR) ? {8'h00, PTR_REG} :
                       (r_state == SETUP_RD || r_state == IDLE) ? 16'h0000 : r_data;
            r_rd    <= (r_state == SETUP_RD) ? 1'b1 :
                       (r_state == SETUP_PTR || r_state == IDLE) ? 1'b0 : r_rd;
            r_valid <= r_state == UPDATE;
            if (r_state == UPDATE) begin
                r_sample <= i2c_read_data;
                r_retry  <= '0;
            end
            if (r_state == FAIL) begin
                r_nack  <= r_nack + 8'(r_nack != 8'hFF);
                r_retry <= (r_retry == 4'(MAX_RETRY)) ? r_retry : r_retry + 4'd1;
                r_fault <= r_fault || (r_retry >= 4'(MAX_RETRY - 1));
            end
            if (r_state == IDLE && !enable) r_fault <= 1'b0;
        end
    end

    assign i2c_addr      = SLAVE_ADDR;
    assign i2c_data      = r_data;
    assign i2c_rw        = r_rd;
    assign i2c_two_bytes = r_rd;
    assign sample        = r_sample;
    assign sample_valid  = r_valid;
    assign nack_count    = r_nack;
    assign fault         = r_fault;
endmodule

// File: tb/tb_i2c_sensor_poller.sv
// tb_i2c_sensor_poller: randomized polls against a behavioural I2C master and a
// poll-level reference model of sample, nack count and fault.
module tb_i2c_sensor_poller;
    localparam int         P    = 40;
    localparam int         BT   = 16;
    localparam int         MR   = 3;
    localparam logic [7:0] PTR  = 8'h5C;
    localparam logic [6:0] ADDR = 7'h48;

    logic        clk = 0, rst = 0, enable = 0, trigger = 0;
    logic        i2c_ready = 1, i2c_got_ack = 0;
    logic [15:0] i2c_read_data = 0;
    logic        i2c_start, i2c_rw, i2c_two_bytes, sample_valid, busy, fault;
    logic [6:0]  i2c_addr;
    logic [15:0] i2c_data, sample;
    logic [7:0]  nack_count;

    int n_vec = 0, n_err = 0;
    int m_fail = 0, m_lat = 0, m_cnt = 0;
    logic m_hang = 0, m_pend = 0, m_cur_rd = 0, m_s;
    logic [15:0] m_data = 0;
    int st_n = 0;
    logic [6:0]  st_addr [4];
    logic [15:0] st_data [4];
    logic        st_rw [4];
    logic        st_two [4];

    logic [15:0] e_sample = 0;
    int e_nack = 0, e_streak = 0;
    logic e_fault = 0;

    i2c_sensor_poller #(.SLAVE_ADDR(ADDR), .PTR_REG(PTR), .POLL_CYCLES(P),
                        .BUSY_TIMEOUT(BT), .MAX_RETRY(MR)) dut (
        .clk(clk), .rst(rst), .enable(enable), .trigger(trigger),
        .i2c_ready(i2c_ready), .i2c_got_ack(i2c_got_ack), .i2c_read_data(i2c_read_data),
        .i2c_start(i2c_start), .i2c_addr(i2c_addr), .i2c_data(i2c_data), .i2c_rw(i2c_rw),
        .i2c_two_bytes(i2c_two_bytes), .sample(sample), .sample_valid(sample_valid),
        .nack_count(nack_count), .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    // Master: ready falls the cycle after a start, rises after a latency with ack/data.
    always @(negedge clk) begin
        m_s = i2c_start;
        if (m_pend && !m_hang) begin
            i2c_ready   = 0;
            i2c_got_ack = 0;
            m_cnt       = m_lat != 0 ? m_lat : int'($urandom_range(2, 6));
        end else if (!i2c_ready) begin
            if (m_cnt <= 1) begin
                i2c_ready     = 1;
                i2c_got_ack   = !((m_fail == 1 && !m_cur_rd) || (m_fail == 2 && m_cur_rd));
                i2c_read_data = m_cur_rd ? m_data : 16'hDEAD;
            end else m_cnt--;
        end
        m_pend = m_s;
        if (m_s) begin
            if (st_n < 4) begin
                st_addr[st_n] = i2c_addr;
                st_data[st_n] = i2c_data;
                st_rw[st_n]   = i2c_rw;
                st_two[st_n]  = i2c_two_bytes;
            end
            st_n++;
            m_cur_rd = i2c_rw;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_start"}, i2c_start, 0);
        chk({tag, "_data"}, i2c_data, 0);
        chk({tag, "_rw"}, i2c_rw, 0);
        chk({tag, "_two"}, i2c_two_bytes, 0);
        chk({tag, "_sample"}, sample, 0);
        chk({tag, "_valid"}, sample_valid, 0);
        chk({tag, "_nack"}, nack_count, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_fault"}, fault, 0);
    endtask

    // Runs one poll from the first IDLE cycle and checks it against the poll-level model.
    task automatic do_poll(input bit trig, input int fm, input bit hang, input logic [15:0] d,
                           input bit mid_trig, input bit mid_dis);
        int n, nb, nv, exp_starts;
        bit ok;
        m_fail = fm; m_hang = hang; m_data = d; st_n = 0; nv = 0; nb = 0;
        n = 0;
        if (trig) begin
            trigger = 1;
            @(negedge clk);
            trigger = 0;
            n = 1;
        end
        while (!i2c_start && n < P + 50) begin
            @(negedge clk);
            n++;
        end
        chk(trig ? "trig_to_start" : "period_to_start", n, trig ? 2 : P + 1);
        for (int g = 0; g < 500; g++) begin
            @(negedge clk);
            trigger = 0;
            if (g == 0 && mid_trig) trigger = 1;
            if (g == 0 && mid_dis) enable = 0;
            nv += int'(sample_valid);
            if (!busy) break;
            nb++;
        end
        trigger = 0;
        chk("poll_end_idle", busy, 0);
        ok = !hang && fm == 0;
        exp_starts = (hang || fm == 1) ? 1 : 2;
        if (ok) begin
            e_sample = d;
            e_streak = 0;
        end else begin
            e_nack   = e_nack < 255 ? e_nack + 1 : 255;
            e_streak = e_streak + 1;
            if (e_streak >= MR) e_fault = 1;
        end
        if (hang) chk("hang_busy_len", nb, BT + 1);
        chk("start_count", st_n, exp_starts);
        chk("ptr_addr", st_addr[0], ADDR);
        chk("ptr_cmd", {st_data[0], st_rw[0], st_two[0]}, {8'h00, PTR, 2'b00});
        if (exp_starts == 2) chk("rd_cmd", {st_addr[1], st_data[1], st_rw[1], st_two[1]},
                                 {ADDR, 16'h0000, 2'b11});
        chk("valid_pulses", nv, ok ? 1 : 0);
        chk("sample", sample, e_sample);
        chk("nack_count", nack_count, e_nack);
        chk("fault", fault, e_fault);
    endtask

    task automatic idle_disabled(input string tag);
        bit seen = 0;
        enable = 0;
        repeat (2 * P) begin
            @(negedge clk);
            seen |= busy;
        end
        e_fault = 0;
        chk({tag, "_stays_idle"}, seen, 0);
        chk({tag, "_fault_clear"}, fault, 0);
        enable = 1;
    endtask

    initial begin
        int r, g, nv;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1; enable = 1;
        do_poll(0, 0, 0, 16'h1A2B, 0, 0);
        do_poll(1, 0, 0, 16'(int'($urandom)), 1, 0);
        do_poll(0, 0, 0, 16'(int'($urandom)), 0, 0);
        repeat (3) do_poll(0, 1, 0, 16'(int'($urandom)), 0, 0);
        chk("fault_after_retries", fault, 1);
        do_poll(0, 0, 0, 16'h00FF, 0, 0);
        idle_disabled("dis");
        do_poll(0, 0, 1, 16'h5555, 0, 0);
        do_poll(0, 2, 0, 16'hAAAA, 0, 0);
        do_poll(0, 0, 0, 16'(int'($urandom)), 0, 1);
        idle_disabled("middis");
        for (int i = 0; i < 25; i++) begin
            r = int'($urandom_range(0, 9));
            do_poll(1'($urandom_range(0, 1)), r < 6 ? 0 : r < 8 ? 1 : r == 8 ? 2 : 0,
                    r == 9, 16'(int'($urandom)), 1'($urandom_range(0, 1)), 0);
        end
        // Reset while the read transaction is still outstanding.
        m_fail = 0; m_hang = 0; m_lat = 20; m_data = 16'hBEEF; st_n = 0;
        trigger = 1;
        @(negedge clk);
        trigger = 0;
        g = 0;
        while (st_n < 2 && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("rd_issued_before_reset", st_n >= 2, 1);
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        m_pend = 0; m_cnt = 0; i2c_ready = 1; m_lat = 0;
        chk_reset_outputs("midrst");
        rst = 1;
        nv = 0;
        repeat (30) begin
            @(negedge clk);
            nv += int'(sample_valid);
        end
        chk("no_valid_after_rst", nv, 0);
        chk("sample_after_rst", sample, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/i2c_sensor_poller.md
Name: i2c_sensor_poller

Overview:
- Transaction sequencer that sits directly upstream of the team's I2C master and drives its command interface.
- It periodically polls one 16-bit register of one slave. Each poll is two transactions:
  - a one-byte pointer write;
  - a two-byte read.
- It publishes each new sample with a valid pulse. It also counts failed address acknowledges and raises a sticky fault after repeated consecutive failures.

Parameters:
- SLAVE_ADDR, 7'h48, 7-bit I2C address of the polled slave.
- PTR_REG, 8'h00, register pointer byte written before each read.
- POLL_CYCLES, 20000, clk cycles between poll starts; legal range 2..65535.
- BUSY_TIMEOUT, 16, cycles allowed for the master's ready to fall after start.
- MAX_RETRY, 3, consecutive failed polls before fault is set; legal range 1..15.

Ports:
- clk  in  1  system clock; the same clk that feeds the I2C master.
- rst  in  1  reset, synchronous and active-low (0 = reset, sampled on rising clk).
- enable  in  1  1 = polling runs; 0 = return to IDLE after the current transaction and clear fault.
- trigger  in  1  one-cycle request for an immediate poll; honoured only in IDLE with enable=1.
- i2c_ready  in  1  master ready.
- i2c_got_ack  in  1  master got_acknowledge; valid once ready returns high.
- i2c_read_data  in  16  master read_data.
- i2c_start  out  1  one-cycle start pulse to the master.
- i2c_addr  out  7  always SLAVE_ADDR.
- i2c_data  out  16  {8'h00, PTR_REG} during the pointer phase; 16'h0000 otherwise.
- i2c_rw  out  1  0 during the pointer phase; 1 during the read phase.
- i2c_two_bytes  out  1  0 during the pointer phase; 1 during the read phase.
- sample  out  16  last good sample.
- sample_valid  out  1  one-cycle pulse when sample updates.
- nack_count  out  8  saturating count of failed transactions (saturates at 255).
- busy  out  1  1 in any state except IDLE.
- fault  out  1  sticky failure flag.

Behaviour:
- Reset values (rst=0 at a clk edge): state=IDLE; timer=POLL_CYCLES-1; retry=0. Every output is 0: i2c_start, i2c_data, i2c_rw, i2c_two_bytes, sample, sample_valid, nack_count, busy, fault.
- Reset mid-transaction aborts immediately. No stop is issued by this block; the master handles its own reset.
- Command outputs (i2c_data/rw/two_bytes) are registered. They are set one cycle before i2c_start and held stable until the WAIT_DONE state exits.
- States and transitions:
  - IDLE:
    - enable=1: timer decrements each cycle.
    - timer==0, or trigger=1 -> SETUP_PTR; reload timer to POLL_CYCLES-1.
    - enable=0: timer is held at reload.
  - SETUP_PTR: drive the pointer command -> ISSUE_PTR.
  - ISSUE_PTR:
    - i2c_ready=1: pulse i2c_start for exactly one cycle -> WAIT_BUSY_PTR.
    - i2c_ready=0: wait here with no start pulse.
  - WAIT_BUSY_PTR:
    - i2c_ready=0 -> WAIT_DONE_PTR.
    - BUSY_TIMEOUT cycles elapse without ready falling -> FAIL.
  - WAIT_DONE_PTR: on i2c_ready=1, sample i2c_got_ack.
    - got_ack=1 -> SETUP_RD.
    - got_ack=0 -> FAIL.
  - SETUP_RD / ISSUE_RD / WAIT_BUSY_RD / WAIT_DONE_RD: same rules as the pointer phase, using the read command.
    - On done with got_ack=1 -> UPDATE.
    - On done with got_ack=0 -> FAIL.
  - UPDATE:
    - sample <= i2c_read_data; sample_valid=1 for this one cycle.
    - retry <= 0 -> IDLE.
  - FAIL:
    - nack_count += 1, saturating at 255.
    - retry += 1; if retry reaches MAX_RETRY, fault <= 1 and retry holds.
    - -> IDLE. The timer is not shortened; retries occur at the normal poll period.
- Fault is sticky: it is cleared only by reset or by enable=0 while in IDLE. Polling continues while fault=1.
- Timing: trigger-to-i2c_start is 2 cycles when the master is ready (IDLE -> SETUP_PTR -> ISSUE_PTR).
- enable falling mid-poll: the current transaction completes, including the read, then the block enters IDLE and stays there.
- trigger and timer==0 in the same cycle produce a single poll.
- trigger outside IDLE is ignored and not queued.
- A failed poll never changes sample and never pulses sample_valid.
- Timer width is 16 bits.

Test Plan:
- Reset then enable=1, with a slave model that ACKs and returns 16'h1A2B:
  - first i2c_start at cycle POLL_CYCLES+1, with i2c_data=16'h0000, rw=0, two_bytes=0;
  - second start with rw=1, two_bytes=1;
  - sample=16'h1A2B with one sample_valid pulse; nack_count=0.
- trigger=1 for one cycle in IDLE with the master ready:
  - i2c_start high exactly 2 cycles later, for exactly 1 cycle;
  - timer restarts from POLL_CYCLES-1.
- Slave NACKs the address on 3 consecutive polls (MAX_RETRY=3):
  - nack_count=3 and fault=1 after the third;
  - sample is unchanged; no sample_valid pulse.
- Then a good poll returning 16'h00FF: sample=16'h00FF and fault stays 1. Then drop enable in IDLE: fault=0.
- Master holds ready=1 after start (hung):
  - FAIL after 16 cycles in WAIT_BUSY; nack_count increments;
  - no second start issued until the next poll period.
- Assert rst=0 during WAIT_DONE_RD:
  - next edge: state IDLE, all outputs 0, sample=0;
  - no sample_valid pulse after rst returns high.
